// File: rtl/one_second_clk_gen.sv
`default_nettype none
// ============================================================================
// Module      : one_second_clk_gen
// Description : Square-wave period generator with rising-edge tick, wrapping
//               seconds count and minute tick on seconds wrap.
// Revision    : 1.0 - initial release
// ============================================================================
module one_second_clk_gen #(
    parameter int unsigned CLK_HZ      = 27000000,
    parameter int unsigned DUTY_CYCLES = 13500000,
    parameter int unsigned SEC_WIDTH   = 6,
    parameter int unsigned SEC_MAX     = 59
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable,
    input  logic                 sync_clr,
    output logic                 oneSecondClk,
    output logic                 tick,
    output logic [SEC_WIDTH-1:0] seconds,
    output logic                 minute_tick,
    output logic                 running
);

    localparam logic [1:0]           c_ST_STOP   = 2'd0;
    localparam logic [1:0]           c_ST_HIGH   = 2'd1;
    localparam logic [1:0]           c_ST_LOW    = 2'd2;
    localparam logic [31:0]          c_DUTY_LAST = 32'(DUTY_CYCLES - 1);
    localparam logic [31:0]          c_DUTY      = 32'(DUTY_CYCLES);
    localparam logic [31:0]          c_PER_LAST  = 32'(CLK_HZ - 1);
    localparam logic [SEC_WIDTH-1:0] c_SEC_MAX   = SEC_WIDTH'(SEC_MAX);
    localparam logic [SEC_WIDTH-1:0] c_SEC_ONE   = SEC_WIDTH'(1);

    logic [1:0]           r_state;
    logic [31:0]          r_cnt;
    logic                 r_osc;
    logic                 r_tick;
    logic                 r_mtick;
    logic [SEC_WIDTH-1:0] r_sec;

    logic [1:0]           w_state_nxt;
    logic [31:0]          w_cnt_nxt;
    logic                 w_osc_nxt;
    logic                 w_tick_nxt;
    logic                 w_mtick_nxt;
    logic [SEC_WIDTH-1:0] w_sec_nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_ST_STOP;
            r_cnt   <= '0;
            r_osc   <= 1'b0;
            r_tick  <= 1'b0;
            r_mtick <= 1'b0;
            r_sec   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_osc   <= w_osc_nxt;
            r_tick  <= w_tick_nxt;
            r_mtick <= w_mtick_nxt;
            r_sec   <= w_sec_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_osc_nxt   = r_osc;
        w_tick_nxt  = 1'b0;
        w_mtick_nxt = 1'b0;
        w_sec_nxt   = r_sec;

        if (sync_clr) begin
            // Restart discards any period end landing in the same cycle
            w_cnt_nxt = '0;
            w_sec_nxt = '0;
            if (enable) begin
                w_state_nxt = c_ST_HIGH;
                w_osc_nxt   = 1'b1;
                w_tick_nxt  = 1'b1;
            end else begin
                w_state_nxt = c_ST_STOP;
                w_osc_nxt   = 1'b0;
            end
        end else if (!enable) begin
            w_state_nxt = c_ST_STOP;
            w_osc_nxt   = 1'b0;
            w_cnt_nxt   = '0;
        end else begin
            case (r_state)
                c_ST_STOP: begin
                    w_state_nxt = c_ST_HIGH;
                    w_osc_nxt   = 1'b1;
                    w_tick_nxt  = 1'b1;
                    w_cnt_nxt   = '0;
                end
                c_ST_HIGH: begin
                    if (r_cnt == c_DUTY_LAST) begin
                        w_state_nxt = c_ST_LOW;
                        w_osc_nxt   = 1'b0;
                        w_cnt_nxt   = c_DUTY;
                    end else begin
                        w_cnt_nxt = r_cnt + 32'd1;
                    end
                end
                c_ST_LOW: begin
                    if (r_cnt == c_PER_LAST) begin
                        w_state_nxt = c_ST_HIGH;
                        w_osc_nxt   = 1'b1;
                        w_tick_nxt  = 1'b1;
                        w_cnt_nxt   = '0;
                        if (r_sec == c_SEC_MAX) begin
                            w_sec_nxt   = '0;
                            w_mtick_nxt = 1'b1;
                        end else begin
                            w_sec_nxt = r_sec + c_SEC_ONE;
                        end
                    end else begin
                        w_cnt_nxt = r_cnt + 32'd1;
                    end
                end
                default: begin
                    w_state_nxt = c_ST_STOP;
                    w_osc_nxt   = 1'b0;
                    w_cnt_nxt   = '0;
                end
            endcase
        end
    end

    assign oneSecondClk = r_osc;
    assign tick         = r_tick;
    assign minute_tick  = r_mtick;
    assign seconds      = r_sec;
    assign running      = (r_state != c_ST_STOP);

endmodule
`default_nettype wire
